// File: rtl/cond_logic_if.sv
// Flag/condition interface between the control decoder and the condition unit.
// master = decoder/datapath side, slave = cond_logic.
interface cond_logic_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] exec_count;
  logic [CNT_W-1:0] skip_count;

  // No handshake: every field is qualified by instr_valid in the same cycle.
  modport master (
    output instr_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags, exec_count, skip_count
  );

  modport slave (
    input  instr_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags, exec_count, skip_count
  );
endinterface

// File: rtl/cond_logic.sv
// ARM condition unit: architectural NZCV register, condition evaluation,
// write gating and saturating executed/skipped instruction counters.
module cond_logic #(
  parameter int CNT_W  = 16,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_exec_cnt;
  logic [CNT_W-1:0] r_skip_cnt;

  logic [3:0] w_eval_flags;
  logic [3:0] w_wr_mask;
  logic       w_cond_ex;
  logic       w_fire;
  logic       w_n, w_z, w_c, w_v;

  assign w_wr_mask = {{2{bus.FlagW[1]}}, {2{bus.FlagW[0]}}};
  assign w_fire    = bus.instr_valid & w_cond_ex;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_fire) begin
      r_flags <= (bus.ALUFlags & w_wr_mask) | (r_flags & ~w_wr_mask);
    end
  end

  // Forwarding path kept for pipelined reuse; in this single-cycle core the
  // forwarded half already equals the registered half, so results are identical.
  generate
    if (BYPASS) begin : g_bypass
      logic [3:0] r_byp_val;
      logic [3:0] r_byp_mask;
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_byp_val  <= 4'b0000;
          r_byp_mask <= 4'b0000;
        end else begin
          r_byp_val  <= bus.ALUFlags;
          r_byp_mask <= w_fire ? w_wr_mask : 4'b0000;
        end
      end
      assign w_eval_flags = (r_byp_val & r_byp_mask) | (r_flags & ~r_byp_mask);
    end else begin : g_no_bypass
      assign w_eval_flags = r_flags;
    end
  endgenerate

  assign {w_n, w_z, w_c, w_v} = w_eval_flags;

  always_comb begin
    w_cond_ex = 1'b1;
    unique case (bus.Cond)
      4'h0: w_cond_ex = w_z;
      4'h1: w_cond_ex = ~w_z;
      4'h2: w_cond_ex = w_c;
      4'h3: w_cond_ex = ~w_c;
      4'h4: w_cond_ex = w_n;
      4'h5: w_cond_ex = ~w_n;
      4'h6: w_cond_ex = w_v;
      4'h7: w_cond_ex = ~w_v;
      4'h8: w_cond_ex = w_c & ~w_z;
      4'h9: w_cond_ex = ~w_c | w_z;
      4'hA: w_cond_ex = (w_n == w_v);
      4'hB: w_cond_ex = (w_n != w_v);
      4'hC: w_cond_ex = ~w_z & (w_n == w_v);
      4'hD: w_cond_ex = w_z | (w_n != w_v);
      4'hE: w_cond_ex = 1'b1;
      4'hF: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_exec_cnt <= '0;
      r_skip_cnt <= '0;
    end else if (bus.instr_valid) begin
      if (w_cond_ex) begin
        if (r_exec_cnt != {CNT_W{1'b1}}) r_exec_cnt <= r_exec_cnt + 1'b1;
      end else begin
        if (r_skip_cnt != {CNT_W{1'b1}}) r_skip_cnt <= r_skip_cnt + 1'b1;
      end
    end
  end

  // Gated writes are held low during reset so a half-reset core cannot commit.
  assign bus.PCSrc      = reset & w_fire & bus.PCS;
  assign bus.RegWrite   = reset & w_fire & bus.RegW & ~bus.NoWrite;
  assign bus.MemWrite   = reset & w_fire & bus.MemW;
  assign bus.CondEx     = w_cond_ex;
  assign bus.Flags      = r_flags;
  assign bus.exec_count = r_exec_cnt;
  assign bus.skip_count = r_skip_cnt;
endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: directed scenarios plus randomized traffic against
// a flag/counter reference model.
module tb_cond_logic;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cond_logic_if #(.CNT_W(16)) bus ();
  cond_logic_if #(.CNT_W(4))  bus4 ();

  cond_logic #(.CNT_W(16), .BYPASS(1'b0)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );
  cond_logic #(.CNT_W(4), .BYPASS(1'b0)) dut4 (
    .clk(clk), .reset(rst4_n), .bus(bus4)
  );

  logic [3:0]  m_flags = 4'b0000;
  logic [15:0] m_exec  = 16'd0;
  logic [15:0] m_skip  = 16'd0;

  function automatic bit cond_eval(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic set_in(input logic valid, input logic [3:0] cond,
                        input logic [3:0] alu, input logic [1:0] fw,
                        input logic pcs, input logic regw, input logic memw,
                        input logic nowr);
    bus.instr_valid = valid; bus.Cond = cond; bus.ALUFlags = alu;
    bus.FlagW = fw; bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw;
    bus.NoWrite = nowr;
  endtask

  // Advance one clock and update the reference model from the sampled inputs.
  task automatic tick();
    bit ce;
    @(posedge clk);
    if (!rst_n) begin
      m_flags = 4'b0000; m_exec = 16'd0; m_skip = 16'd0;
    end else if (bus.instr_valid) begin
      ce = cond_eval(bus.Cond, m_flags);
      if (ce) begin
        if (bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
        if (bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
        if (m_exec != 16'hFFFF) m_exec = m_exec + 16'd1;
      end else if (m_skip != 16'hFFFF) begin
        m_skip = m_skip + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1'b1, 4'hE, 4'($urandom_range(0, 15)), 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if ({bus.PCSrc, bus.RegWrite, bus.MemWrite} !== 3'b000) begin
      errors++; $display("FAIL reset_gated got %b want 000", {bus.PCSrc, bus.RegWrite, bus.MemWrite});
    end
    tick(); tick();
    checks++;
    if (bus.Flags !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", bus.Flags);
    end
    checks++;
    if (bus.exec_count !== 16'd0 || bus.skip_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.exec_count, bus.skip_count);
    end
    rst_n = 1'b1;
    set_in(1'b1, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.RegWrite !== 1'b1) begin
      errors++; $display("FAIL release_regwrite got %b want 1", bus.RegWrite);
    end
    tick();
    checks++;
    if (bus.exec_count !== 16'd1) begin
      errors++; $display("FAIL release_exec got %0d want 1", bus.exec_count);
    end
  endtask

  task automatic test_flag_write();
    logic [15:0] s0;
    set_in(1'b1, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.Flags !== 4'b0100) begin
      errors++; $display("FAIL flag_write got %b want 0100", bus.Flags);
    end
    set_in(1'b1, 4'h0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.MemWrite !== 1'b1) begin
      errors++; $display("FAIL eq_memwrite got %b want 1", bus.MemWrite);
    end
    tick();
    set_in(1'b1, 4'h1, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.MemWrite !== 1'b0) begin
      errors++; $display("FAIL ne_memwrite got %b want 0", bus.MemWrite);
    end
    s0 = m_skip;
    tick();
    checks++;
    if (bus.skip_count !== s0 + 16'd1) begin
      errors++; $display("FAIL ne_skip got %0d want %0d", bus.skip_count, s0 + 16'd1);
    end
  endtask

  task automatic test_half_write();
    set_in(1'b1, 4'hE, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 4'hE, 4'b1011, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.Flags !== 4'b1000) begin
      errors++; $display("FAIL half_nz got %b want 1000", bus.Flags);
    end
    set_in(1'b1, 4'hE, 4'b0111, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.Flags !== 4'b1011) begin
      errors++; $display("FAIL half_cv got %b want 1011", bus.Flags);
    end
  endtask

  task automatic test_cond_sweep();
    bit exp;
    for (int f = 0; f < 16; f++) begin
      set_in(1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int c = 0; c < 16; c++) begin
        set_in(1'b0, 4'(c), 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        exp = cond_eval(4'(c), 4'(f));
        checks++;
        if (bus.CondEx !== exp || bus.PCSrc !== 1'b0) begin
          errors++; $display("FAIL sweep f=%h c=%h got %b/%b want %b/0", f, c, bus.CondEx, bus.PCSrc, exp);
        end
      end
      tick();
    end
    set_in(1'b1, 4'hE, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 4'hA, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (bus.CondEx !== 1'b1) begin errors++; $display("FAIL ge_1001 got %b want 1", bus.CondEx); end
    bus.Cond = 4'hB; #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin errors++; $display("FAIL lt_1001 got %b want 0", bus.CondEx); end
    bus.Cond = 4'hC; #1;
    checks++;
    if (bus.CondEx !== 1'b1) begin errors++; $display("FAIL gt_1001 got %b want 1", bus.CondEx); end
    set_in(1'b1, 4'hE, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 4'hA, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (bus.CondEx !== 1'b0) begin errors++; $display("FAIL ge_1000 got %b want 0", bus.CondEx); end
    bus.Cond = 4'hD; #1;
    checks++;
    if (bus.CondEx !== 1'b1) begin errors++; $display("FAIL le_1000 got %b want 1", bus.CondEx); end
    tick();
  endtask

  task automatic test_suppressed();
    set_in(1'b1, 4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 4'h1, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.Flags !== 4'b0100) begin
      errors++; $display("FAIL ne_suppress got %b want 0100", bus.Flags);
    end
    set_in(1'b1, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if (bus.RegWrite !== 1'b0) begin
      errors++; $display("FAIL nowrite got %b want 0", bus.RegWrite);
    end
    tick();
  endtask

  task automatic test_random();
    bit ce;
    logic [2:0] exp_g;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      set_in(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      ce = cond_eval(bus.Cond, m_flags);
      exp_g = {3{rst_n & bus.instr_valid & ce}} &
              {bus.PCS, bus.RegW & !bus.NoWrite, bus.MemW};
      checks++;
      if (bus.CondEx !== ce || {bus.PCSrc, bus.RegWrite, bus.MemWrite} !== exp_g) begin
        errors++; $display("FAIL rand_comb i=%0d got %b/%b want %b/%b", i, bus.CondEx,
                           {bus.PCSrc, bus.RegWrite, bus.MemWrite}, ce, exp_g);
      end
      tick();
      checks++;
      if (bus.Flags !== m_flags || bus.exec_count !== m_exec || bus.skip_count !== m_skip) begin
        errors++; $display("FAIL rand_state i=%0d got %b/%0d/%0d want %b/%0d/%0d", i, bus.Flags,
                           bus.exec_count, bus.skip_count, m_flags, m_exec, m_skip);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    int m4;
    bus.instr_valid = 1'b0;
    bus4.instr_valid = 1'b0; bus4.Cond = 4'hE; bus4.ALUFlags = 4'b0000;
    bus4.FlagW = 2'b00; bus4.PCS = 1'b0; bus4.RegW = 1'b0; bus4.MemW = 1'b0;
    bus4.NoWrite = 1'b0;
    rst4_n = 1'b0;
    tick();
    rst4_n = 1'b1;
    m4 = 0;
    bus4.instr_valid = 1'b1; bus4.FlagW = 2'b11; bus4.ALUFlags = 4'b1010;
    for (int i = 0; i < 20; i++) begin
      tick();
      m4 = (m4 < 15) ? m4 + 1 : 15;
      checks++;
      if (bus4.exec_count !== 4'(m4)) begin
        errors++; $display("FAIL sat_step i=%0d got %0d want %0d", i, bus4.exec_count, m4);
      end
    end
    checks++;
    if (bus4.exec_count !== 4'hF || bus4.Flags !== 4'b1010) begin
      errors++; $display("FAIL sat_final got %h/%b want f/1010", bus4.exec_count, bus4.Flags);
    end
    rst4_n = 1'b0;
    bus4.FlagW = 2'b11; bus4.ALUFlags = 4'b1111;
    tick();
    checks++;
    if (bus4.Flags !== 4'b0000 || bus4.exec_count !== 4'h0 || bus4.skip_count !== 4'h0) begin
      errors++; $display("FAIL sat_reset got %b/%h/%h want 0000/0/0", bus4.Flags,
                         bus4.exec_count, bus4.skip_count);
    end
    rst4_n = 1'b1;
    bus4.instr_valid = 1'b0;
  endtask

  initial begin
    bus4.instr_valid = 1'b0; bus4.Cond = 4'hE; bus4.ALUFlags = 4'b0000;
    bus4.FlagW = 2'b00; bus4.PCS = 1'b0; bus4.RegW = 1'b0; bus4.MemW = 1'b0;
    bus4.NoWrite = 1'b0;
    set_in(1'b0, 4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_flag_write();
    test_half_write();
    test_cond_sweep();
    test_suppressed();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
